mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: RAM_DEPTH, 128, number of byte locations in internal RAM at addresses 0x00..RAM_DEPTH-1 (power of two, max 128).
REQ-002 Parameter: WAIT_CYCLES, 2, extra ACCESS-state cycles inserted per request when MEM_WAIT_EN is defined (1..15).
REQ-003 Parameter: IO_ADDR, 8'hFF, address of the memory-mapped output register.
REQ-004 Port: clk  input  1  clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: memread_i  input  1  read request strobe from the control unit.
REQ-007 Port: memwrite_i  input  1  write request strobe from the control unit.
REQ-008 Port: addr_i  input  8  byte address of the request.
REQ-009 Port: wdata_i  input  8  write data.
REQ-010 Port: rdata_o  output  8  read data, registered.
REQ-011 Port: ready_o  output  1  one-cycle completion pulse.
REQ-012 Port: busy_o  output  1  high whenever state is not IDLE.
REQ-013 Port: err_o  output  1  one-cycle pulse on an illegal request.
REQ-014 Port: io_out_o  output  8  memory-mapped output register contents.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, ACCESS, DONE.
REQ-016 In IDLE, exactly one of memread_i/memwrite_i high SHALL latch addr_i, wdata_i and the request type, and the FSM SHALL move to ACCESS.
REQ-017 In IDLE, memread_i and memwrite_i both high SHALL pulse err_o for one cycle, perform no access, and keep the FSM in IDLE.
REQ-018 Requests arriving in ACCESS or DONE SHALL be ignored; they are not queued.
REQ-019 Without MEM_WAIT_EN, ACCESS SHALL last one cycle; with it, ACCESS SHALL last 1+WAIT_CYCLES cycles, counted by a 4-bit down-counter loaded on entry.
REQ-020 On the final ACCESS cycle the access SHALL be performed. A read loads rdata_o. A write updates RAM or io_out_o. The FSM then moves to DONE.
REQ-021 DONE SHALL last one cycle with ready_o=1, then return to IDLE. Base latency SHALL be 2 cycles from the request edge to ready_o.
REQ-022 A read at an address < RAM_DEPTH SHALL return the RAM byte.
REQ-023 A read at IO_ADDR SHALL return io_out_o.
REQ-024 A read at any other address SHALL return 8'h00 and pulse err_o in DONE.
REQ-025 A write at an address < RAM_DEPTH SHALL update the RAM byte.
REQ-026 A write at IO_ADDR SHALL update io_out_o.
REQ-027 A write at any other address SHALL be discarded and SHALL pulse err_o in DONE.
REQ-028 rdata_o SHALL hold its value until the next completed read; writes SHALL NOT change it.
REQ-029 A read following a write to the same address SHALL return the newly written value.
REQ-030 busy_o SHALL be high in ACCESS and DONE.

Reset
REQ-031 On rst: FSM=IDLE, rdata_o=0, io_out_o=0, ready_o=0, err_o=0, busy_o=0, wait counter=0.
REQ-032 RAM contents SHALL NOT be cleared by reset.
REQ-033 rst asserted during ACCESS SHALL abort the request. A pending write SHALL NOT be committed, and no ready_o pulse SHALL follow.
REQ-034 rst SHALL take priority over any request sampled in the same cycle.

Configuration
REQ-035 Macro MEM_RESPONDER_WAIT_EN, when defined, SHALL compile in the wait-state counter and WAIT_CYCLES extra ACCESS cycles. Undefined, the counter SHALL be absent and ACCESS SHALL always be one cycle.

Verification
REQ-036 Write 8'hA5 to 0x10, then read 0x10 -> ready_o 2 cycles after each request; rdata_o=8'hA5.
REQ-037 Write 8'h3C to 0xFF -> io_out_o=8'h3C after DONE. Read 0xFF -> rdata_o=8'h3C.
REQ-038 Read 0x90 with RAM_DEPTH=128 -> rdata_o=8'h00 and err_o pulse in DONE. Write 0x90 -> err_o pulse; RAM unchanged.
REQ-039 memread_i=memwrite_i=1 in IDLE -> err_o pulse the next cycle, busy_o stays 0, no ready_o.
REQ-040 With MEM_RESPONDER_WAIT_EN and WAIT_CYCLES=2, read 0x00 -> ready_o 4 cycles after the request. A second request issued while busy_o=1 is ignored.
REQ-041 Write 8'h77 to 0x05, assert rst in ACCESS -> no ready_o, FSM IDLE. A later read of 0x05 returns its prior value.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: single-port byte memory responder with a memory-mapped
// output register, driven by read/write strobes from a control unit.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous, active-high reset
//   memread_i  read request strobe (sampled in IDLE only)
//   memwrite_i write request strobe (sampled in IDLE only)
//   addr_i     byte address of the request
//   wdata_i    write data
//   rdata_o    registered read data, held until the next completed read
//   ready_o    one-cycle completion pulse (DONE state)
//   busy_o     high whenever the FSM is not IDLE
//   err_o      one-cycle pulse on an illegal request or unmapped address
//   io_out_o   memory-mapped output register (address IO_ADDR)
//
// Build option: define MEM_RESPONDER_WAIT_EN to add WAIT_CYCLES extra
// ACCESS cycles per request via a 4-bit down-counter. Undefined, ACCESS
// is always a single cycle and the counter does not exist.
module mem_responder #(
  parameter int unsigned RAM_DEPTH   = 128,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [7:0]  IO_ADDR     = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       memread_i,
  input  logic       memwrite_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       ready_o,
  output logic       busy_o,
  output logic       err_o,
  output logic [7:0] io_out_o
);

  localparam int unsigned AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0] state;
  logic       is_write_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] mem [RAM_DEPTH];

  logic start;
  logic illegal;
  logic access_last;
  logic do_access;
  logic hit_ram;
  logic hit_io;

  assign start     = (state == S_IDLE) && (memread_i ^ memwrite_i);
  assign illegal   = (state == S_IDLE) && memread_i && memwrite_i;
  assign do_access = (state == S_ACCESS) && access_last;
  assign hit_ram   = ({24'd0, addr_q} < RAM_DEPTH);
  assign hit_io    = (addr_q == IO_ADDR);
  assign busy_o    = (state != S_IDLE);

`ifdef MEM_RESPONDER_WAIT_EN
  logic [3:0] wait_cnt;

  assign access_last = (wait_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (start) begin
      wait_cnt <= 4'(WAIT_CYCLES);
    end else if ((state == S_ACCESS) && !access_last) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end
`else
  assign access_last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_o    <= '0;
      io_out_o   <= '0;
      ready_o    <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      err_o   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            is_write_q <= memwrite_i;
            addr_q     <= addr_i;
            wdata_q    <= wdata_i;
            state      <= S_ACCESS;
          end else if (illegal) begin
            err_o <= 1'b1;
          end
        end
        S_ACCESS: begin
          if (access_last) begin
            state   <= S_DONE;
            ready_o <= 1'b1;
            if (is_write_q) begin
              // RAM writes are committed in the storage block below.
              if (!hit_ram) begin
                if (hit_io) io_out_o <= wdata_q;
                else        err_o    <= 1'b1;
              end
            end else begin
              if (hit_ram) begin
                rdata_o <= mem[addr_q[AW-1:0]];
              end else if (hit_io) begin
                rdata_o <= io_out_o;
              end else begin
                rdata_o <= '0;
                err_o   <= 1'b1;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage has no reset so contents survive rst; gating on !rst keeps a
  // write aborted by reset from landing.
  always_ff @(posedge clk) begin
    if (!rst && do_access && is_write_q && hit_ram) begin
      mem[addr_q[AW-1:0]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

`ifdef MEM_RESPONDER_WAIT_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       memread_i = 1'b0;
  logic       memwrite_i = 1'b0;
  logic [7:0] addr_i = '0;
  logic [7:0] wdata_i = '0;
  logic [7:0] rdata_o;
  logic       ready_o;
  logic       busy_o;
  logic       err_o;
  logic [7:0] io_out_o;

  mem_responder #(
    .RAM_DEPTH  (128),
    .WAIT_CYCLES(2),
    .IO_ADDR    (8'hFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memread_i (memread_i),
    .memwrite_i(memwrite_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o),
    .err_o     (err_o),
    .io_out_o  (io_out_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         ready;
    bit         err;
    logic [7:0] rdata;
    logic [7:0] io;
    int         lat;
    int         req_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops one expectation per response.
  always @(negedge clk) begin
    cyc++;
    if (ready_o || err_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_response: ready=%0b err=%0b busy=%0b expected none", ready_o, err_o, busy_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ready", 32'(ready_o), 32'(e.ready));
        check("err", 32'(err_o), 32'(e.err));
        check("busy", 32'(busy_o), 32'(e.ready));
        check("latency", 32'(cyc - e.req_cyc), 32'(e.lat));
        check("rdata", 32'(rdata_o), 32'(e.rdata));
        check("io_out", 32'(io_out_o), 32'(e.io));
      end
    end
  end

  task automatic drive(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    memread_i  = rd;
    memwrite_i = wr;
    addr_i     = a;
    wdata_i    = d;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // Issue one request for one cycle and queue what the DUT must answer.
  task automatic req(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                     input bit e_ready, input bit e_err, input logic [7:0] e_rdata,
                     input logic [7:0] e_io, input int e_lat);
    exp_t e;
    @(negedge clk);
    #1;
    drive(rd, wr, a, d);
    e.ready = e_ready; e.err = e_err; e.rdata = e_rdata; e.io = e_io;
    e.lat = e_lat; e.req_cyc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_rdata", 32'(rdata_o), 32'h0);
    check("rst_io", 32'(io_out_o), 32'h0);
    check("rst_ready", 32'(ready_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);

    // write then read back through RAM
    req(0, 1, 8'h10, 8'hA5, 1, 0, 8'h00, 8'h00, LAT); wait_done();
    req(1, 0, 8'h10, 8'h00, 1, 0, 8'hA5, 8'h00, LAT); wait_done();
    // IO register write leaves rdata untouched, then read it back
    req(0, 1, 8'hFF, 8'h3C, 1, 0, 8'hA5, 8'h3C, LAT); wait_done();
    req(1, 0, 8'hFF, 8'h00, 1, 0, 8'h3C, 8'h3C, LAT); wait_done();
    // unmapped addresses: read returns 0 with err, write discarded with err
    req(1, 0, 8'h90, 8'h00, 1, 1, 8'h00, 8'h3C, LAT); wait_done();
    req(0, 1, 8'h90, 8'h5A, 1, 1, 8'h00, 8'h3C, LAT); wait_done();
    // 0x90 aliases 0x10 in the low 7 bits; RAM must be unchanged
    req(1, 0, 8'h10, 8'h00, 1, 0, 8'hA5, 8'h3C, LAT); wait_done();
    // both strobes: err next cycle, no ready, busy stays low
    req(1, 1, 8'h10, 8'h77, 0, 1, 8'hA5, 8'h3C, 1); wait_done();
    check("illegal_no_write_busy", 32'(busy_o), 32'h0);
    req(1, 0, 8'h10, 8'h00, 1, 0, 8'hA5, 8'h3C, LAT); wait_done();
    // RAM top boundary and first out-of-range address
    req(0, 1, 8'h7F, 8'hC3, 1, 0, 8'hA5, 8'h3C, LAT); wait_done();
    req(1, 0, 8'h7F, 8'h00, 1, 0, 8'hC3, 8'h3C, LAT); wait_done();
    req(1, 0, 8'h80, 8'h00, 1, 1, 8'h00, 8'h3C, LAT); wait_done();
    req(0, 1, 8'h05, 8'h11, 1, 0, 8'h00, 8'h3C, LAT); wait_done();

    // requests while busy are dropped
    req(1, 0, 8'h05, 8'h00, 1, 0, 8'h11, 8'h3C, LAT);
    for (int i = 0; i < 2; i++) begin
      check("busy_during_req", 32'(busy_o), 32'h1);
      drive(1'b0, 1'b1, 8'h05, 8'hEE);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 8'h00, 8'h00);
    end
    wait_done();
    req(1, 0, 8'h05, 8'h00, 1, 0, 8'h11, 8'h3C, LAT); wait_done();

    // reset during ACCESS aborts the write, no ready follows
    @(negedge clk);
    #1;
    drive(1'b0, 1'b1, 8'h05, 8'h77);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    check("busy_in_access", 32'(busy_o), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy_o), 32'h0);
    check("abort_io", 32'(io_out_o), 32'h0);
    check("abort_rdata", 32'(rdata_o), 32'h0);
    repeat (6) @(negedge clk);
    req(1, 0, 8'h05, 8'h00, 1, 0, 8'h11, 8'h00, LAT); wait_done();

    // reset wins over a request in the same cycle
    @(negedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b1, 8'h05, 8'h99);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    check("rst_priority_busy", 32'(busy_o), 32'h0);
    repeat (4) @(negedge clk);
    req(1, 0, 8'h05, 8'h00, 1, 0, 8'h11, 8'h00, LAT); wait_done();

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

endmodule
